// File: rtl/store_buffer_pkg.sv
// Shared types for the store write buffer: drain FSM states and the buffered entry format.
package store_buffer_pkg;

    localparam int SWB_ADDR_W       = 32;
    localparam int SWB_DATA_W       = 32;
    localparam int WORD_OFFSET_BITS = 2;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

    typedef struct packed {
        logic [SWB_ADDR_W-1:0] addr;
        logic [SWB_DATA_W-1:0] data;
    } store_entry_t;

    // Stores are word-sized, so the byte offset is dropped before buffering.
    function automatic logic [SWB_ADDR_W-1:0] word_align(input logic [SWB_ADDR_W-1:0] a);
        return {a[SWB_ADDR_W-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/store_forward_match.sv
// Youngest-match search over the pending stores for load forwarding.
module store_forward_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int PTR_WIDTH     = 2,
    parameter int ADDRESS_WIDTH = SWB_ADDR_W,
    parameter int DATA_WIDTH    = SWB_DATA_W
) (
    input  store_entry_t               i_entries [DEPTH],
    input  logic [DEPTH-1:0]           i_valid,
    input  logic [PTR_WIDTH-1:0]       i_tail,
    input  logic [ADDRESS_WIDTH-1:0]   i_load_addr,
    output logic                       o_hit,
    output logic [DATA_WIDTH-1:0]      o_data
);

    logic [PTR_WIDTH-1:0] w_idx;

    // Walk from the slot at tail (oldest position) towards tail-1 (youngest);
    // later matches override earlier ones, so the youngest store wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_tail + PTR_WIDTH'(k);
            if (i_valid[w_idx] &&
                (i_entries[w_idx].addr[ADDRESS_WIDTH-1:WORD_OFFSET_BITS] ==
                 i_load_addr[ADDRESS_WIDTH-1:WORD_OFFSET_BITS])) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: queues CPU stores, drains them to memory over req/ack, forwards to loads.
module store_write_buffer
    import store_buffer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = SWB_ADDR_W,
    parameter int DATA_WIDTH    = SWB_DATA_W,
    parameter int DEPTH         = 4,
    parameter int PTR_WIDTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] store_addr_i,
    input  logic [DATA_WIDTH-1:0]    store_data_i,
    output logic                     store_ready_o,
    input  logic [ADDRESS_WIDTH-1:0] load_addr_i,
    output logic                     fwd_hit_o,
    output logic [DATA_WIDTH-1:0]    fwd_data_o,
    output logic                     mem_req_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_data_o,
    input  logic                     mem_ack_i,
    output logic                     empty_o,
    output logic [PTR_WIDTH:0]       count_o
);

    store_entry_t          r_entries [DEPTH];
    logic [PTR_WIDTH-1:0]  r_head;
    logic [PTR_WIDTH-1:0]  r_tail;
    logic [PTR_WIDTH:0]    r_count;
    drain_state_t          r_state;
    drain_state_t          w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [ADDRESS_WIDTH-1:0] w_mem_addr_next;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic [DATA_WIDTH-1:0] w_mem_data_next;
    logic                  w_push;
    logic                  w_pop;
    logic [PTR_WIDTH:0]    w_count_after;
    logic [PTR_WIDTH-1:0]  w_head_inc;
    logic [DEPTH-1:0]      w_valid;

    // Handshakes: a store transfers on store_valid_i && store_ready_o; a drain
    // transfers on mem_req_o && mem_ack_i. Ready depends on registered count only.
    assign store_ready_o = (r_count != (PTR_WIDTH+1)'(DEPTH));
    assign w_push        = store_valid_i && store_ready_o;
    assign w_pop         = (r_state == DRAIN_REQ) && mem_ack_i;
    assign w_count_after = r_count + (PTR_WIDTH+1)'(w_push) - (PTR_WIDTH+1)'(w_pop);
    assign w_head_inc    = r_head + PTR_WIDTH'(1);

    assign mem_req_o  = (r_state == DRAIN_REQ);
    assign mem_addr_o = r_mem_addr;
    assign mem_data_o = r_mem_data;
    assign empty_o    = (r_count == '0);
    assign count_o    = r_count;

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = ({1'b0, PTR_WIDTH'(i) - r_head} < r_count);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_mem_addr_next = r_mem_addr;
        w_mem_data_next = r_mem_data;
        case (r_state)
            DRAIN_IDLE: begin
                if (r_count != '0) begin
                    w_state_next    = DRAIN_REQ;
                    w_mem_addr_next = r_entries[r_head].addr;
                    w_mem_data_next = r_entries[r_head].data;
                end
            end
            DRAIN_REQ: begin
                if (mem_ack_i) begin
                    if (w_count_after == '0) begin
                        w_state_next = DRAIN_IDLE;
                    end else if (r_count == (PTR_WIDTH+1)'(1)) begin
                        // The next head is the store landing on this very edge.
                        w_mem_addr_next = word_align(store_addr_i);
                        w_mem_data_next = store_data_i;
                    end else begin
                        w_mem_addr_next = r_entries[w_head_inc].addr;
                        w_mem_data_next = r_entries[w_head_inc].data;
                    end
                end
            end
            default: w_state_next = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DRAIN_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state    <= w_state_next;
            r_mem_addr <= w_mem_addr_next;
            r_mem_data <= w_mem_data_next;
            r_count    <= w_count_after;
            if (w_push) r_tail <= r_tail + PTR_WIDTH'(1);
            if (w_pop)  r_head <= w_head_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_entries[r_tail] <= '{addr: word_align(store_addr_i), data: store_data_i};
        end
    end

    store_forward_match #(
        .DEPTH         (DEPTH),
        .PTR_WIDTH     (PTR_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_fwd (
        .i_entries   (r_entries),
        .i_valid     (w_valid),
        .i_tail      (r_tail),
        .i_load_addr (load_addr_i),
        .o_hit       (fwd_hit_o),
        .o_data      (fwd_data_o)
    );

endmodule
